// File: rtl/packet_aware_fifo_asym_pkg.sv
// packet_aware_fifo_asym_pkg: width-ratio helper and parameter sanity checks for the packet FIFO
package packet_aware_fifo_asym_pkg;
  function automatic int ratio_log2(input int din_w, input int dout_w);
    return $clog2(din_w / dout_w);
  endfunction
  function automatic bit widths_ok(input int din_w, input int dout_w, input int addr_msb, input int limit_w);
    return (din_w % dout_w == 0) && (din_w / dout_w == (1 << $clog2(din_w / dout_w))) && (limit_w >= addr_msb + 1);
  endfunction
endpackage

// File: rtl/sdp_ram_asym.sv
// sdp_ram_asym: simple dual-port RAM, wide write port A, narrow registered read port B
module sdp_ram_asym #(
  parameter int DIN_WIDTH  = 64,
  parameter int DOUT_WIDTH = 16,
  parameter int AW         = 10,
  parameter int K          = 2
) (
  input  logic                  CLK,
  input  logic                  ena,
  input  logic [AW-1:0]         addra,
  input  logic [DIN_WIDTH-1:0]  dina,
  input  logic                  enb,
  input  logic [AW+K-1:0]       addrb,
  output logic [DOUT_WIDTH-1:0] doutb
);
  localparam int RW = AW + K;
  logic [DOUT_WIDTH-1:0] mem [2**RW];
  always_ff @(posedge CLK) begin
    if (ena)
      for (int i = 0; i < (1 << K); i++)
        mem[(RW'(addra) << K) + RW'(i)] <= dina[i*DOUT_WIDTH +: DOUT_WIDTH];
    if (enb) doutb <= mem[addrb];
  end
endmodule

// File: rtl/packet_aware_fifo_asym.sv
// packet_aware_fifo_asym: committed-packet FWFT FIFO with width downsizing, abort rollback and output limit
module packet_aware_fifo_asym
  import packet_aware_fifo_asym_pkg::*;
#(
  parameter int DIN_WIDTH   = 64,
  parameter int DOUT_WIDTH  = 16,
  parameter int ADDR_MSB    = 9,
  parameter int LIMIT_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   rst,
  input  logic [DIN_WIDTH-1:0]   din,
  input  logic                   wr_en,
  input  logic                   pkt_end,
  input  logic                   pkt_abort,
  output logic                   full,
  output logic                   err_overflow,
  output logic                   err_overflow_seen,
  input  logic                   rd_en,
  output logic [DOUT_WIDTH-1:0]  dout,
  output logic                   empty,
  input  logic                   mode_limit,
  input  logic                   reg_output_limit,
  input  logic [LIMIT_WIDTH-1:0] output_limit_min,
  output logic [LIMIT_WIDTH-1:0] output_limit,
  output logic                   output_limit_done
);
  localparam int K  = ratio_log2(DIN_WIDTH, DOUT_WIDTH);
  localparam int AW = ADDR_MSB + 1;
  localparam int RW = AW + K;
  if (!widths_ok(DIN_WIDTH, DOUT_WIDTH, ADDR_MSB, LIMIT_WIDTH)) begin : g_bad_params
    $error("packet_aware_fifo_asym: unsupported width/limit parameters");
  end
  logic [AW-1:0] wr_ptr, committed, lim_ptr, rd_word, avail, min_cmp;
  logic [RW-1:0] rd_ptr;
  logic [DOUT_WIDTH-1:0] ram_dout;
  logic wr_acc, enb, enb_r, wft, load;
  assign rd_word = rd_ptr[RW-1:K];
  assign full = rst | (wr_ptr + AW'(1) == rd_word);
  assign wr_acc = wr_en & ~full & ~pkt_abort;
  assign err_overflow = full & (committed == rd_word);
  assign avail = committed - lim_ptr;
  assign min_cmp = (output_limit_min > LIMIT_WIDTH'(2**AW - 1)) ? '1 : output_limit_min[AW-1:0];
  assign output_limit_done = lim_ptr == rd_word;
  assign empty = rst | ~wft;
  // fetch only reserved data, and only when the output stage can move
  assign enb = (lim_ptr != rd_word) & (empty | rd_en);
  assign load = enb_r & (~wft | rd_en);
  sdp_ram_asym #(
    .DIN_WIDTH (DIN_WIDTH),
    .DOUT_WIDTH(DOUT_WIDTH),
    .AW        (AW),
    .K         (K)
  ) u_ram (
    .CLK  (CLK),
    .ena  (wr_acc),
    .addra(wr_ptr),
    .dina (din),
    .enb  (enb),
    .addrb(rd_ptr),
    .doutb(ram_dout)
  );
  always_ff @(posedge CLK)
    if (rst) begin
      wr_ptr            <= '0;
      committed         <= '0;
      lim_ptr           <= '0;
      rd_ptr            <= '0;
      output_limit      <= '0;
      err_overflow_seen <= 1'b0;
      enb_r             <= 1'b0;
      wft               <= 1'b0;
    end else begin
      if (pkt_abort) wr_ptr <= committed;
      else if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (pkt_end) committed <= wr_ptr + AW'(1);
      end
      if (err_overflow) err_overflow_seen <= 1'b1;
      if (!mode_limit || (reg_output_limit && avail >= min_cmp)) begin
        lim_ptr      <= committed;
        output_limit <= LIMIT_WIDTH'(avail);
      end else if (reg_output_limit) output_limit <= '0;
      if (enb) rd_ptr <= rd_ptr + RW'(1);
      if (empty | rd_en) enb_r <= enb;
      if (load) wft <= 1'b1;
      else if (rd_en) wft <= 1'b0;
    end
  always_ff @(posedge CLK)
    if (!rst && load) dout <= ram_dout;
endmodule
